// File: rtl/s1_pkg.sv
// Shared S1 core types: widths, ALU op codes and the execute request payload.
package s1_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SRL  = 4'h5,
        ALU_SRA  = 4'h6,
        ALU_SLL  = 4'h7,
        ALU_ADDC = 4'h8,
        ALU_SLTU = 4'h9
    } alu_op_e;

    // Raw decoded instruction as offered by decode; also the skid payload.
    typedef struct packed {
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rs1_addr;
        logic [RA_W-1:0] rs2_addr;
        logic [RA_W-1:0] rd;
        logic            use_imm;
        alu_op_e         alu_op;
        logic            rd_we;
    } ex_req_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } ex_state_e;

endpackage

// File: rtl/alu.sv
// 32-bit S1 ALU. Codes 8/9 are ADDC/SLTU; every other code uses op[2:0].
module alu
    import s1_pkg::*;
(
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    logic [XLEN:0] sum;

    // Result select; SLL sees the full b so any amount >= 32 clears the result.
    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        y   = '0;
        if (op == ALU_ADDC) begin
            y = {{(XLEN-1){1'b0}}, sum[XLEN]};
        end else if (op == ALU_SLTU) begin
            y = {{(XLEN-1){1'b0}}, (a < b)};
        end else begin
            case (op[2:0])
                3'd0: y = sum[XLEN-1:0];
                3'd1: y = a - b;
                3'd2: y = a & b;
                3'd3: y = a | b;
                3'd4: y = a ^ b;
                3'd5: y = a >> b[4:0];
                3'd6: y = $signed(a) >>> b[4:0];
                default: y = (|b[XLEN-1:5]) ? '0 : (a << b[4:0]);
            endcase
        end
    end

endmodule

// File: rtl/ex_bypass.sv
// Per-source forwarding: own out register first, then writeback, else regfile.
module ex_bypass
    import s1_pkg::*;
(
    input  logic [RA_W-1:0] addr,
    input  logic [XLEN-1:0] rf_val,
    input  logic            out_hit_en,
    input  logic [RA_W-1:0] out_rd,
    input  logic [XLEN-1:0] out_val,
    input  logic            wb_we,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] val
);

    // x0 is hardwired to zero in the regfile, so it is never forwarded.
    always_comb begin
        val = rf_val;
        if (addr != '0) begin
            if (out_hit_en && out_rd == addr)
                val = out_val;
            else if (wb_we && wb_rd == addr)
                val = wb_data;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// S1 execute stage: 2-entry elastic buffer (out register + raw skid) around the ALU.
module ex_stage
    import s1_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    input  logic [RA_W-1:0] in_rs1_addr,
    input  logic [RA_W-1:0] in_rs2_addr,
    input  logic [3:0]      in_alu_op,
    input  logic [RA_W-1:0] in_rd,
    input  logic            in_rd_we,
    input  logic            wb_we,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RA_W-1:0] out_rd,
    output logic            out_rd_we
);

    ex_state_e       state, next_state;
    ex_req_t         in_req, skid_q, src;
    logic            accept, pop;
    logic            load_out, load_skid, use_skid;
    logic [XLEN-1:0] rs1_byp, rs2_byp, alu_b, alu_y;

    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_valid = (state != ST_EMPTY);

    // Pack the decode inputs into the request struct.
    always_comb begin
        in_req          = '0;
        in_req.rs1_val  = in_rs1_val;
        in_req.rs2_val  = in_rs2_val;
        in_req.imm      = in_imm;
        in_req.rs1_addr = in_rs1_addr;
        in_req.rs2_addr = in_rs2_addr;
        in_req.rd       = in_rd;
        in_req.use_imm  = in_use_imm;
        in_req.alu_op   = alu_op_e'(in_alu_op);
        in_req.rd_we    = in_rd_we;
    end

    // State register; in_ready is registered from next_state to cut the ready path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != ST_TWO);
        end
    end

    // Next-state: occupancy count driven by accept/pop; flush empties everything.
    always_comb begin
        next_state = state;
        case (state)
            ST_EMPTY: if (accept) next_state = ST_ONE;
            ST_ONE: begin
                if (accept && !pop)      next_state = ST_TWO;
                else if (!accept && pop) next_state = ST_EMPTY;
            end
            ST_TWO:   if (pop) next_state = ST_ONE;
            default:  next_state = ST_EMPTY;
        endcase
        if (flush) next_state = ST_EMPTY;
    end

    // Load controls: the out register refills from input or skid, skid only catches overflow.
    always_comb begin
        use_skid  = (state == ST_TWO);
        load_out  = !flush && (((state == ST_EMPTY) && accept) ||
                               ((state == ST_ONE) && accept && pop) ||
                               ((state == ST_TWO) && pop));
        load_skid = !flush && (state == ST_ONE) && accept && !pop;
    end

    assign src   = use_skid ? skid_q : in_req;
    assign alu_b = src.use_imm ? src.imm : rs2_byp;

    ex_bypass u_byp_rs1 (
        .addr(src.rs1_addr), .rf_val(src.rs1_val),
        .out_hit_en(out_valid & out_rd_we), .out_rd(out_rd), .out_val(out_result),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .val(rs1_byp)
    );

    ex_bypass u_byp_rs2 (
        .addr(src.rs2_addr), .rf_val(src.rs2_val),
        .out_hit_en(out_valid & out_rd_we), .out_rd(out_rd), .out_val(out_result),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .val(rs2_byp)
    );

    alu u_alu (
        .op(src.alu_op), .a(rs1_byp), .b(alu_b), .y(alu_y)
    );

    // Out register: only written on load, so it holds steady under back-pressure and flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result <= '0;
            out_rd     <= '0;
            out_rd_we  <= 1'b0;
        end else if (load_out) begin
            out_result <= alu_y;
            out_rd     <= src.rd;
            out_rd_we  <= src.rd_we;
        end
    end

    // Skid register: raw operands, evaluated later when promoted to the out register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         skid_q <= '0;
        else if (load_skid) skid_q <= in_req;
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: handshake, ALU ops, bypass, skid, flush, async reset.
module tb_ex_stage;
    import s1_pkg::*;

    logic        clk, rst_n, flush;
    logic        in_valid, in_ready;
    logic [31:0] in_rs1_val, in_rs2_val, in_imm;
    logic        in_use_imm;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd;
    logic [3:0]  in_alu_op;
    logic        in_rd_we;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_rd_we;

    int n_chk  = 0;
    int n_fail = 0;

    ex_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_alu_op(in_alu_op), .in_rd(in_rd), .in_rd_we(in_rd_we),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_rd_we(out_rd_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [4:0] a1, input logic [31:0] v1,
                          input logic [4:0] a2, input logic [31:0] v2,
                          input logic [31:0] imm, input logic ui,
                          input logic [3:0] op, input logic [4:0] rd, input logic we);
        in_valid    = 1'b1;
        in_rs1_addr = a1;  in_rs1_val = v1;
        in_rs2_addr = a2;  in_rs2_val = v2;
        in_imm      = imm; in_use_imm = ui;
        in_alu_op   = op;  in_rd = rd; in_rd_we = we;
    endtask

    // Single instruction through an empty stage, then drain.
    task automatic issue(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        set_in(5'd1, a, 5'd2, b, 32'd0, 1'b0, op, 5'd9, 1'b1);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk(tag, out_result, exp);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_rs1_val = '0; in_rs2_val = '0; in_imm = '0; in_use_imm = 1'b0;
        in_rs1_addr = '0; in_rs2_addr = '0; in_alu_op = '0; in_rd = '0; in_rd_we = 1'b0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;

        // Reset state
        #12;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result",    out_result,         32'd0);
        chk("rst_rd",        {27'd0, out_rd},    32'd0);
        chk("rst_rd_we",     {31'd0, out_rd_we}, 32'd0);
        rst_n = 1'b1;

        // Basic ADD, one-cycle latency
        set_in(5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, 4'd0, 5'd3, 1'b1);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("add_valid",  {31'd0, out_valid}, 32'd1);
        chk("add_result", out_result,         32'd12);
        chk("add_rd",     {27'd0, out_rd},    32'd3);
        tick();
        chk("add_drained", {31'd0, out_valid}, 32'd0);

        // ALU op coverage
        issue("sub",       4'd1, 32'd5,        32'd7,  32'hFFFF_FFFE);
        issue("sra",       4'd6, 32'h8000_0000, 32'd4, 32'hF800_0000);
        issue("srl_b36",   4'd5, 32'h100,      32'd36, 32'h10);
        issue("sll_31",    4'd7, 32'd1,        32'd31, 32'h8000_0000);
        issue("sll_b33",   4'd7, 32'd1,        32'd33, 32'h0);
        issue("addc",      4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1);
        issue("xor_alias", 4'hC, 32'hF0,       32'hFF, 32'h0F);
        issue("or",        4'd3, 32'hF0,       32'h0F, 32'hFF);

        // Back-pressure fill to TWO
        out_ready = 1'b0;
        set_in(5'd1, 32'hF0F0, 5'd2, 32'hFF00, 32'd0, 1'b0, 4'd2, 5'd6, 1'b1);
        tick();
        chk("bp_and",      out_result,        32'hF000);
        chk("bp_ready1",   {31'd0, in_ready}, 32'd1);
        set_in(5'd1, 32'd3, 5'd2, 32'd5, 32'd0, 1'b0, 4'd9, 5'd7, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("bp_ready0",   {31'd0, in_ready}, 32'd0);
        chk("bp_hold1",    out_result,        32'hF000);
        tick();
        chk("bp_hold2",    out_result,        32'hF000);
        chk("bp_hold_rd",  {27'd0, out_rd},   32'd6);
        chk("bp_hold_vld", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_sltu",     out_result,        32'd1);
        chk("bp_sltu_rd",  {27'd0, out_rd},   32'd7);
        chk("bp_ready_rt", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_drained",  {31'd0, out_valid}, 32'd0);

        // Bypass priority: out register beats writeback, both on x4
        set_in(5'd0, 32'd10, 5'd0, 32'd0, 32'd0, 1'b0, 4'd0, 5'd4, 1'b1);
        tick();
        chk("byp_x4", out_result, 32'd10);
        set_in(5'd4, 32'd0, 5'd1, 32'd1, 32'd0, 1'b0, 4'd0, 5'd8, 1'b1);
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'd99;
        tick();
        chk("byp_prio", out_result, 32'd11);
        // x0 destination in the out register, wb also on x0: neither forwards
        set_in(5'd0, 32'd10, 5'd0, 32'd0, 32'd0, 1'b0, 4'd0, 5'd0, 1'b1);
        wb_we = 1'b0;
        tick();
        set_in(5'd0, 32'd0, 5'd1, 32'd1, 32'd0, 1'b0, 4'd0, 5'd8, 1'b1);
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'd99;
        tick();
        chk("byp_x0", out_result, 32'd1);
        in_valid = 1'b0; wb_we = 1'b0;
        tick();
        // Writeback-only forwarding with immediate operand
        set_in(5'd9, 32'd0, 5'd0, 32'd0, 32'd5, 1'b1, 4'd0, 5'd2, 1'b1);
        wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'd50;
        tick();
        in_valid = 1'b0; wb_we = 1'b0;
        chk("byp_wb", out_result, 32'd55);
        tick();

        // Skid instruction forwards from the stalled out register when promoted
        out_ready = 1'b0;
        set_in(5'd0, 32'h20, 5'd0, 32'd0, 32'd0, 1'b0, 4'd0, 5'd5, 1'b1);
        tick();
        set_in(5'd5, 32'd0, 5'd0, 32'd0, 32'd4, 1'b1, 4'd5, 5'd6, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("skid_hold", out_result, 32'h20);
        out_ready = 1'b1;
        tick();
        chk("skid_byp",  out_result, 32'h2);
        tick();

        // Flush in TWO with in_valid high
        out_ready = 1'b0;
        set_in(5'd1, 32'd1, 5'd2, 32'd1, 32'd0, 1'b0, 4'd0, 5'd1, 1'b1);
        tick();
        tick();
        chk("fl_two_ready", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_ready", {31'd0, in_ready},  32'd1);
        out_ready = 1'b1;
        tick();
        chk("fl_quiet1", {31'd0, out_valid}, 32'd0);
        tick();
        chk("fl_quiet2", {31'd0, out_valid}, 32'd0);
        // Flush discards a same-cycle accept from EMPTY
        set_in(5'd1, 32'd1, 5'd2, 32'd1, 32'd0, 1'b0, 4'd0, 5'd1, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_acc_drop", {31'd0, out_valid}, 32'd0);

        // Async reset mid-cycle while holding one instruction
        out_ready = 1'b0;
        set_in(5'd1, 32'd3, 5'd2, 32'd4, 32'd0, 1'b0, 4'd0, 5'd2, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("ar_pre", out_result, 32'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid",  {31'd0, out_valid}, 32'd0);
        chk("ar_result", out_result,         32'd0);
        chk("ar_rd",     {27'd0, out_rd},    32'd0);
        chk("ar_rd_we",  {31'd0, out_rd_we}, 32'd0);
        chk("ar_ready",  {31'd0, in_ready},  32'd1);
        #2 rst_n = 1'b1;
        tick();
        chk("ar_post", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
